// File: rtl/bmult_bitheap_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : bmult_bitheap_sched_if
//  Brief    : Requester, multiplier and response bundle for the bit-heap
//             multiplier scheduler.
//  Revision : 1.0
// ============================================================================
interface bmult_bitheap_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 28
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;

    logic                   mul_issue;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic [2*WIDTH-1:0]     mul_result;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_data;

    // Environment side: requesters, multiplier datapath and response consumer.
    modport master (
        output req_valid, req_a, req_b, mul_result, rsp_ready,
        input  req_ready, mul_issue, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, mul_result, rsp_ready,
        output req_ready, mul_issue, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/bmult_bitheap_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bmult_bitheap_sched
//  Brief    : Round-robin scheduler sharing one pipelined bit-heap multiplier
//             among N_REQ requesters, with tag realignment and a credit-
//             protected result FIFO.
//  Revision : 1.0
// ============================================================================
module bmult_bitheap_sched #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 28,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bmult_bitheap_sched_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int P_W   = 2 * WIDTH;
    localparam int CR_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CR_W-1:0]  c_full_credits = CR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] c_last_slot    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [ID_W-1:0]  c_last_id      = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]    c_n_req        = (ID_W + 1)'(N_REQ);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CR_W-1:0]  r_credits;
    logic             r_tag_vld [MUL_LAT];
    logic [ID_W-1:0]  r_tag_id  [MUL_LAT];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CR_W-1:0]  r_count;
    logic [ID_W-1:0]  r_mem_id   [FIFO_DEPTH];
    logic [P_W-1:0]   r_mem_data [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic             w_found;
    logic [ID_W-1:0]  w_gnt;
    logic [ID_W:0]    w_sum;
    logic             w_issue;
    logic [N_REQ-1:0] w_req_ready;
    logic [WIDTH-1:0] w_mul_a;
    logic [WIDTH-1:0] w_mul_b;
    logic             w_rsp_valid;
    logic             w_pop;
    logic             w_push;

    // Scan requesters starting at the round-robin pointer, modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            if (w_sum >= c_n_req) begin
                w_sum = w_sum - c_n_req;
            end
            if (!w_found && bus.req_valid[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_sum[ID_W-1:0];
            end
        end
    end

    // A grant always means a handshake, because only valid requesters win.
    assign w_issue = rst_n && (r_credits != '0) && w_found;

    always_comb begin
        w_req_ready = '0;
        w_mul_a     = '0;
        w_mul_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_issue && (w_gnt == ID_W'(i))) begin
                w_req_ready[i] = 1'b1;
                w_mul_a        = bus.req_a[i*WIDTH +: WIDTH];
                w_mul_b        = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready;
    assign w_push      = r_tag_vld[MUL_LAT-1];

    // ------------------------------------------------------------------------
    // Round-robin pointer and credit counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_credits <= c_full_credits;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= (w_gnt == c_last_id) ? '0 : w_gnt + ID_W'(1);
            end
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - CR_W'(1);
                2'b01:   r_credits <= r_credits + CR_W'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Tag pipeline: follows the multiplier so the ID lands with its product
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_id[s]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_gnt;
            for (int s = MUL_LAT - 1; s > 0; s--) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result FIFO (first-word fall-through, no write bypass)
    // ------------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == c_last_slot) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits bound the occupancy, so a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                r_mem_id[e]   <= '0;
                r_mem_data[e] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_id[r_wr_ptr]   <= r_tag_id[MUL_LAT-1];
                r_mem_data[r_wr_ptr] <= bus.mul_result;
                r_wr_ptr             <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CR_W'(1);
                2'b01:   r_count <= r_count - CR_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready = w_req_ready;
    assign bus.mul_issue = w_issue;
    assign bus.mul_a     = w_mul_a;
    assign bus.mul_b     = w_mul_b;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = r_mem_id[r_rd_ptr];
    assign bus.rsp_data  = r_mem_data[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_bmult_bitheap_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bmult_bitheap_sched
//  Brief    : Directed vector table plus randomized traffic against a
//             queue-based reference model of the scheduler.
//  Revision : 1.0
// ============================================================================
module tb_bmult_bitheap_sched;
    localparam int N = 4;
    localparam int W = 28;
    localparam int L = 1;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bmult_bitheap_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

    bmult_bitheap_sched #(.N_REQ(N), .WIDTH(W), .MUL_LAT(L), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier stand-in: registered product, L stages deep.
    logic [2*W-1:0] mpipe [L];
    always @(posedge clk) begin
        mpipe[0] <= 56'(bus.mul_a) * 56'(bus.mul_b);
        for (int s = L - 1; s > 0; s--) mpipe[s] <= mpipe[s-1];
    end
    assign bus.mul_result = mpipe[L-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: queues of in-flight and buffered products
    // ------------------------------------------------------------------------
    typedef struct { int rem; int id; logic [2*W-1:0] data; } fly_t;
    typedef struct { int id; logic [2*W-1:0] data; } rsp_t;

    fly_t           m_fly[$];
    rsp_t           m_fifo[$];
    int             m_ptr = 0;
    int             m_credits = D;
    bit             m_just_reset = 1'b1;
    int             m_g = -1;
    logic [W-1:0]   op_a [N];
    logic [W-1:0]   op_b [N];

    task automatic drive(input logic rst, input logic [N-1:0] rv, input logic rr, input logic maxop);
        rst_n         = rst;
        bus.req_valid = rv;
        bus.rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            op_a[i] = maxop ? {W{1'b1}} : W'($urandom);
            op_b[i] = maxop ? {W{1'b1}} : W'($urandom);
            bus.req_a[i*W +: W] = op_a[i];
            bus.req_b[i*W +: W] = op_b[i];
        end
    endtask

    task automatic model_check();
        logic [N-1:0] e_ready;
        logic [W-1:0] e_a;
        logic [W-1:0] e_b;
        e_ready = '0;
        e_a = '0;
        e_b = '0;
        m_g = -1;
        if (rst_n && m_credits > 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_g < 0 && bus.req_valid[idx]) m_g = idx;
            end
        end
        if (m_g >= 0) begin
            e_ready[m_g] = 1'b1;
            e_a = op_a[m_g];
            e_b = op_b[m_g];
        end
        chk("model req_ready", 64'(bus.req_ready), 64'(e_ready));
        chk("model mul_issue", 64'(bus.mul_issue), 64'(m_g >= 0));
        chk("model mul_a", 64'(bus.mul_a), 64'(e_a));
        chk("model mul_b", 64'(bus.mul_b), 64'(e_b));
        chk("model rsp_valid", 64'(bus.rsp_valid), 64'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            chk("model rsp_id", 64'(bus.rsp_id), 64'(m_fifo[0].id));
            chk("model rsp_data", 64'(bus.rsp_data), 64'(m_fifo[0].data));
        end else if (m_just_reset) begin
            chk("reset rsp_id", 64'(bus.rsp_id), 64'd0);
            chk("reset rsp_data", 64'(bus.rsp_data), 64'd0);
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_fly.delete();
            m_fifo.delete();
            m_ptr = 0;
            m_credits = D;
            m_just_reset = 1'b1;
        end else begin
            m_just_reset = 1'b0;
            if (m_fifo.size() > 0 && bus.rsp_ready) begin
                void'(m_fifo.pop_front());
                m_credits++;
            end
            foreach (m_fly[i]) m_fly[i].rem--;
            while (m_fly.size() > 0 && m_fly[0].rem == 0) begin
                m_fifo.push_back('{id: m_fly[0].id, data: m_fly[0].data});
                void'(m_fly.pop_front());
            end
            if (m_g >= 0) begin
                m_credits--;
                m_fly.push_back('{rem: L, id: m_g,
                                  data: {{W{1'b0}}, op_a[m_g]} * {{W{1'b0}}, op_b[m_g]}});
                m_ptr = (m_g + 1) % N;
            end
        end
        if (m_credits < 0 || m_credits > D || m_fifo.size() > D) begin
            n_tests++;
            n_fail++;
            $display("FAIL model bounds: credits %0d fifo %0d", m_credits, m_fifo.size());
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic           rst;
        logic [N-1:0]   rv;
        logic           rr;
        logic           maxop;
        logic [N-1:0]   exp_ready;
        logic           exp_vld;
        int             exp_id;
        logic           chk_data;
        logic [2*W-1:0] exp_data;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic [N-1:0] rv, input logic rr,
                                input logic [N-1:0] er, input logic ev, input int eid);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rr = rr; v.maxop = 1'b0;
        v.exp_ready = er; v.exp_vld = ev; v.exp_id = eid;
        v.chk_data = 1'b0; v.exp_data = '0;
        return v;
    endfunction

    initial begin
        vec_t v;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;

        // Reset, then single max-operand product
        vt.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0));
        v = mk(1, 4'b0001, 1, 4'b0001, 0, 0); v.maxop = 1'b1; vt.push_back(v);
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0));
        v = mk(1, 4'b0000, 1, 4'b0000, 1, 0); v.chk_data = 1'b1;
        v.exp_data = 56'hFFFFFFE0000001; vt.push_back(v);
        // Fairness with everyone requesting
        vt.push_back(mk(1, 4'b1111, 1, 4'b0010, 0, 0));
        vt.push_back(mk(1, 4'b1111, 1, 4'b0100, 0, 0));
        vt.push_back(mk(1, 4'b1111, 1, 4'b1000, 1, 1));
        vt.push_back(mk(1, 4'b1111, 1, 4'b0001, 1, 2));
        vt.push_back(mk(1, 4'b1111, 1, 4'b0010, 1, 3));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 0));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 1));
        // Backpressure: exactly D issues, then stall
        vt.push_back(mk(1, 4'b1111, 0, 4'b0100, 0, 0));
        vt.push_back(mk(1, 4'b1111, 0, 4'b1000, 0, 0));
        vt.push_back(mk(1, 4'b1111, 0, 4'b0001, 1, 2));
        vt.push_back(mk(1, 4'b1111, 0, 4'b0010, 1, 2));
        vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 2));
        vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 2));
        // One pop frees one credit, spent on the next cycle
        vt.push_back(mk(1, 4'b1111, 1, 4'b0000, 1, 2));
        vt.push_back(mk(1, 4'b1111, 0, 4'b0100, 1, 3));
        vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 3));
        vt.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 3));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 3));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 0));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 1));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 2));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0));
        // Pointer wrap from 3 back to 0, then 1
        vt.push_back(mk(1, 4'b1001, 1, 4'b1000, 0, 0));
        vt.push_back(mk(1, 4'b1001, 1, 4'b0001, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 3));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 0));
        vt.push_back(mk(1, 4'b0010, 1, 4'b0010, 0, 0));
        // Reset with one buffered and one in-flight product
        vt.push_back(mk(1, 4'b0100, 1, 4'b0100, 0, 0));
        vt.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 1));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0));
        vt.push_back(mk(1, 4'b0001, 1, 4'b0001, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 0));
        vt.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0));

        foreach (vt[r]) begin
            drive(vt[r].rst, vt[r].rv, vt[r].rr, vt[r].maxop);
            @(negedge clk);
            model_check();
            chk($sformatf("vec%0d req_ready", r), 64'(bus.req_ready), 64'(vt[r].exp_ready));
            chk($sformatf("vec%0d rsp_valid", r), 64'(bus.rsp_valid), 64'(vt[r].exp_vld));
            if (vt[r].exp_vld)
                chk($sformatf("vec%0d rsp_id", r), 64'(bus.rsp_id), 64'(vt[r].exp_id));
            if (vt[r].chk_data)
                chk($sformatf("vec%0d rsp_data", r), 64'(bus.rsp_data), 64'(vt[r].exp_data));
            @(posedge clk);
            model_update();
            #1;
        end

        // Randomized traffic with varying backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            logic rr;
            int   bias;
            bias = (c / 500) % 3;
            rr = (bias == 0) ? 1'b1 : (bias == 1) ? ($urandom_range(0, 3) == 0)
                                                  : ($urandom_range(0, 1) == 0);
            drive($urandom_range(0, 199) != 0, N'($urandom), rr, $urandom_range(0, 19) == 0);
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
